// File: rtl/tube_pkg.sv
// Shared constants for the multiplexed seven-segment display controller:
// register offsets, CTRL bit positions and hex-to-segment patterns.
package tube_pkg;

  // Register word offsets relative to the end of the DATA block.
  localparam int unsigned AUX_OFS_AFTER_DATA  = 0;
  localparam int unsigned CTRL_OFS_AFTER_DATA = 1;

  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_LZS_BIT   = 1;
  localparam int unsigned CTRL_BLINK_BIT = 2;
  localparam logic [2:0]  CTRL_RESET     = 3'b001;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-high {dp,g..a} patterns for hex digits 0..F.
  localparam logic [7:0] HEX_0 = 8'h3F;
  localparam logic [7:0] HEX_1 = 8'h06;
  localparam logic [7:0] HEX_2 = 8'h5B;
  localparam logic [7:0] HEX_3 = 8'h4F;
  localparam logic [7:0] HEX_4 = 8'h66;
  localparam logic [7:0] HEX_5 = 8'h6D;
  localparam logic [7:0] HEX_6 = 8'h7D;
  localparam logic [7:0] HEX_7 = 8'h07;
  localparam logic [7:0] HEX_8 = 8'h7F;
  localparam logic [7:0] HEX_9 = 8'h6F;
  localparam logic [7:0] HEX_A = 8'h77;
  localparam logic [7:0] HEX_B = 8'h7C;
  localparam logic [7:0] HEX_C = 8'h39;
  localparam logic [7:0] HEX_D = 8'h5E;
  localparam logic [7:0] HEX_E = 8'h79;
  localparam logic [7:0] HEX_F = 8'h71;

  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_seg = HEX_0;
      4'h1:    hex_seg = HEX_1;
      4'h2:    hex_seg = HEX_2;
      4'h3:    hex_seg = HEX_3;
      4'h4:    hex_seg = HEX_4;
      4'h5:    hex_seg = HEX_5;
      4'h6:    hex_seg = HEX_6;
      4'h7:    hex_seg = HEX_7;
      4'h8:    hex_seg = HEX_8;
      4'h9:    hex_seg = HEX_9;
      4'hA:    hex_seg = HEX_A;
      4'hB:    hex_seg = HEX_B;
      4'hC:    hex_seg = HEX_C;
      4'hD:    hex_seg = HEX_D;
      4'hE:    hex_seg = HEX_E;
      4'hF:    hex_seg = HEX_F;
      default: hex_seg = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational nibble-to-segment decoder; output is active-low, blank forces all segments off.
module seg7_decoder
  import tube_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [7:0] seg
);

  // Invert the active-high pattern for the active-low tube drivers.
  always_comb begin
    if (blank) begin
      seg = SEG_OFF;
    end else begin
      seg = ~hex_seg(nibble);
    end
  end

endmodule

// File: rtl/digital_tube_ctrl.sv
// Memory-mapped multiplexed seven-segment controller: NUM_GROUPS 4-digit groups plus one aux tube.
// Optional blink support is built when TUBE_BLINK_EN is defined.
module digital_tube_ctrl
  import tube_pkg::*;
#(
  parameter int unsigned NUM_GROUPS = 2,
  parameter int unsigned SCAN_DIV   = 25000,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_7f50
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [3:0]              byteen,
  input  logic [31:0]             Addr,
  input  logic [31:0]             WD,
  output logic [31:0]             RD,
  output logic [31:0]             tube_num,
  output logic [8*NUM_GROUPS-1:0] seg_out,
  output logic [4*NUM_GROUPS-1:0] sel_out,
  output logic [7:0]              aux_seg,
  output logic                    aux_sel
);

  localparam int unsigned NUM_WORDS = (NUM_GROUPS + 1) / 2;
  localparam int unsigned DIV_W     = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [29:0] AUX_OFS  = 30'(NUM_WORDS + AUX_OFS_AFTER_DATA);
  localparam logic [29:0] CTRL_OFS = 30'(NUM_WORDS + CTRL_OFS_AFTER_DATA);
`ifdef TUBE_BLINK_EN
  localparam logic [2:0] CTRL_MASK = 3'b111;
`else
  localparam logic [2:0] CTRL_MASK = 3'b011;
`endif

  logic [31:0]             data_r [NUM_WORDS];
  logic [7:0]              aux_r;
  logic [2:0]              ctrl_r;
  logic [DIV_W-1:0]        div_cnt_r;
  logic [1:0]              idx_r;
  logic [29:0]             offset_s;
  logic [31:0]             data_rd_s;
  logic [32*NUM_WORDS-1:0] data_flat_s;
  logic [8*NUM_GROUPS-1:0] dec_seg_s;
  logic [3:0]              sel_digit_s;
  logic                    blink_off_s;
  logic                    sel_on_s;
  logic                    unused_addr_s;

  // Byte offset bits are ignored; wrap-around subtraction pushes addresses below base out of range.
  assign offset_s      = Addr[31:2] - BASE_ADDR[31:2];
  assign unused_addr_s = ^Addr[1:0];
  assign tube_num      = data_r[0];

  // Register file writes with per-lane byte enables.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_WORDS; k++) data_r[k] <= 32'h0;
      aux_r  <= 8'h00;
      ctrl_r <= CTRL_RESET;
    end else if (we) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        if (offset_s == 30'(k)) begin
          for (int b = 0; b < 4; b++) begin
            if (byteen[b]) data_r[k][8*b +: 8] <= WD[8*b +: 8];
          end
        end
      end
      if (offset_s == AUX_OFS && byteen[0]) aux_r <= WD[7:0];
      if (offset_s == CTRL_OFS && byteen[0]) ctrl_r <= WD[2:0] & CTRL_MASK;
    end
  end

  // Read mux over DATA words, flattened nibble view for the scanners.
  always_comb begin
    data_rd_s   = 32'h0;
    data_flat_s = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      data_rd_s |= (offset_s == 30'(k)) ? data_r[k] : 32'h0;
      data_flat_s[32*k +: 32] = data_r[k];
    end
  end

  // Combinational read-back; writes in the same cycle are not forwarded.
  always_comb begin
    if (offset_s < 30'(NUM_WORDS)) begin
      RD = data_rd_s;
    end else if (offset_s == AUX_OFS) begin
      RD = {24'h0, aux_r};
    end else if (offset_s == CTRL_OFS) begin
      RD = {29'h0, ctrl_r};
    end else begin
      RD = 32'h0;
    end
  end

  // Scan divider and shared digit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_r <= '0;
      idx_r     <= 2'd0;
    end else if (div_cnt_r == DIV_LAST) begin
      div_cnt_r <= '0;
      idx_r     <= idx_r + 2'd1;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

`ifdef TUBE_BLINK_EN
  logic [23:0] blink_cnt_r;

  // Free-running blink timebase; selects go dark while the MSB is set.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_r <= 24'h0;
    end else begin
      blink_cnt_r <= blink_cnt_r + 24'h1;
    end
  end
  assign blink_off_s = ctrl_r[CTRL_BLINK_BIT] & blink_cnt_r[23];
`else
  assign blink_off_s = 1'b0;
`endif

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
    logic [15:0] grp_s;
    logic [3:0]  nib_s;
    logic        lead_zero_s;
    logic [7:0]  seg_s;

    assign grp_s = data_flat_s[16*g +: 16];
    assign nib_s = grp_s[{idx_r, 2'b00} +: 4];

    // Leading zero: this digit and every higher digit of the group are zero.
    always_comb begin
      case (idx_r)
        2'd1:    lead_zero_s = (grp_s[15:4] == 12'h000);
        2'd2:    lead_zero_s = (grp_s[15:8] == 8'h00);
        2'd3:    lead_zero_s = (grp_s[15:12] == 4'h0);
        default: lead_zero_s = 1'b0;
      endcase
    end

    seg7_decoder u_dec (
      .nibble (nib_s),
      .blank  (lead_zero_s & ctrl_r[CTRL_LZS_BIT]),
      .seg    (seg_s)
    );

    assign dec_seg_s[8*g +: 8] = seg_s;
  end

  assign sel_digit_s = ~(4'b0001 << idx_r);
  assign sel_on_s    = ctrl_r[CTRL_EN_BIT] & ~blink_off_s;

  // Registered tube drive; everything off during reset or when disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_out <= '1;
      sel_out <= '1;
      aux_seg <= SEG_OFF;
      aux_sel <= 1'b1;
    end else begin
      seg_out <= ctrl_r[CTRL_EN_BIT] ? dec_seg_s : '1;
      sel_out <= sel_on_s ? {NUM_GROUPS{sel_digit_s}} : '1;
      aux_seg <= ctrl_r[CTRL_EN_BIT] ? ~aux_r : SEG_OFF;
      aux_sel <= ~sel_on_s;
    end
  end

endmodule

// File: tb/tb_digital_tube_ctrl.sv
// Self-checking bench for digital_tube_ctrl (NUM_GROUPS=2, SCAN_DIV=4): register vector table,
// hand sequences for scan/LZS/enable/reset corners, and randomized traffic against a reference model.
module tb_digital_tube_ctrl;

  localparam int NG = 2;
  localparam int SD = 4;
  localparam int NW = (NG + 1) / 2;
  localparam logic [31:0] BASE = 32'h0000_7f50;
`ifdef TUBE_BLINK_EN
  localparam logic [2:0] CTRL_WMASK = 3'b111;
`else
  localparam logic [2:0] CTRL_WMASK = 3'b011;
`endif

  logic          clk = 1'b0;
  logic          reset, we;
  logic [3:0]    byteen;
  logic [31:0]   Addr, WD, RD, tube_num;
  logic [8*NG-1:0] seg_out;
  logic [4*NG-1:0] sel_out;
  logic [7:0]    aux_seg;
  logic          aux_sel;

  always #5 clk = ~clk;

  digital_tube_ctrl #(.NUM_GROUPS(NG), .SCAN_DIV(SD), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .we(we), .byteen(byteen), .Addr(Addr), .WD(WD), .RD(RD),
    .tube_num(tube_num), .seg_out(seg_out), .sel_out(sel_out), .aux_seg(aux_seg), .aux_sel(aux_sel)
  );

  int passed = 0;
  int total  = 0;

  // Reference model state: registers plus clocks elapsed since reset.
  logic [31:0] m_data [NW];
  logic [7:0]  m_aux;
  logic [2:0]  m_ctrl;
  int          m_ticks;
  logic [8*NG-1:0] e_seg;
  logic [4*NG-1:0] e_sel;
  logic [7:0]  e_aux_seg;
  logic        e_aux_sel;

  logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [3:0] digit(input int g, input int i);
    int n = 4 * g + i;
    return 4'((m_data[n / 8] >> (4 * (n % 8))) & 32'hF);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) - (BASE >> 2));
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    int w = word_of(a);
    if (w >= 0 && w < NW) return m_data[w];
    if (w == NW) return {24'h0, m_aux};
    if (w == NW + 1) return {29'h0, m_ctrl};
    return 32'h0;
  endfunction

  // Called right after each rising edge: outputs follow the pre-edge state, then state updates.
  task automatic model_edge();
    int idx, w;
    logic blank;
    if (reset) begin
      e_seg = '1; e_sel = '1; e_aux_seg = 8'hFF; e_aux_sel = 1'b1;
      for (int k = 0; k < NW; k++) m_data[k] = 32'h0;
      m_aux = 8'h00; m_ctrl = 3'b001; m_ticks = 0;
    end else begin
      idx = (m_ticks / SD) % 4;
      for (int g = 0; g < NG; g++) begin
        blank = m_ctrl[1] && idx > 0;
        for (int j = idx; j < 4; j++) if (digit(g, j) != 4'h0) blank = 1'b0;
        e_seg[8*g +: 8] = (!m_ctrl[0] || blank) ? 8'hFF : ~seg_tab[digit(g, idx)];
        e_sel[4*g +: 4] = m_ctrl[0] ? 4'(~(4'b0001 << idx)) : 4'hF;
      end
      e_aux_seg = m_ctrl[0] ? ~m_aux : 8'hFF;
      e_aux_sel = !m_ctrl[0];
      if (we) begin
        w = word_of(Addr);
        if (w >= 0 && w < NW) begin
          for (int b = 0; b < 4; b++) if (byteen[b]) m_data[w][8*b +: 8] = WD[8*b +: 8];
        end else if (w == NW && byteen[0]) m_aux = WD[7:0];
        else if (w == NW + 1 && byteen[0]) m_ctrl = WD[2:0] & CTRL_WMASK;
      end
      m_ticks++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("seg_out", 32'(seg_out), 32'(e_seg));
    chk("sel_out", 32'(sel_out), 32'(e_sel));
    chk("aux_seg", 32'(aux_seg), 32'(e_aux_seg));
    chk("aux_sel", 32'(aux_sel), 32'(e_aux_sel));
    chk("tube_num", tube_num, m_data[0]);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    we = 1'b1; Addr = a; byteen = be; WD = d;
    tick();
    we = 1'b0; byteen = 4'h0;
  endtask

  function automatic int active_digit(input logic [3:0] s);
    int d = 0;
    for (int j = 0; j < 4; j++) if (!s[j]) d = j;
    return d;
  endfunction

  typedef struct {
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [11];
  logic [7:0] g1_exp [4] = '{8'hB0, 8'hA4, 8'hF9, 8'hC0};
  logic [7:0] lzs_g0 [4] = '{8'hC0, 8'h92, 8'hFF, 8'hFF};
  logic [7:0] lzs_g1 [4] = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};

  initial begin
    vecs[0]  = '{4'hF, 32'h7f50, 32'h0123_456F, 32'h0123_456F};
    vecs[1]  = '{4'h2, 32'h7f50, 32'hAABB_CCDD, 32'h0123_CC6F};
    vecs[2]  = '{4'h5, 32'h7f50, 32'h1122_3344, 32'h0122_CC44};
    vecs[3]  = '{4'hF, 32'h7f54, 32'h1234_5678, 32'h0000_0078};
    vecs[4]  = '{4'h1, 32'h7f54, 32'h0000_00A5, 32'h0000_00A5};
    vecs[5]  = '{4'hF, 32'h7f58, 32'hFFFF_FFFF, {29'h0, CTRL_WMASK}};
    vecs[6]  = '{4'hE, 32'h7f58, 32'h0000_0000, {29'h0, CTRL_WMASK}};
    vecs[7]  = '{4'hF, 32'h7f5C, 32'h1234_5678, 32'h0000_0000};
    vecs[8]  = '{4'hF, 32'h7f4C, 32'h1234_5678, 32'h0000_0000};
    vecs[9]  = '{4'hF, 32'h7f53, 32'h0000_0050, 32'h0000_0050};
    vecs[10] = '{4'hF, 32'h7f58, 32'h0000_0001, 32'h0000_0001};

    reset = 1'b1; we = 1'b0; byteen = 4'h0; Addr = 32'h0; WD = 32'h0;
    tick(); tick();
    chk("reset_sel", 32'(sel_out), 32'h0000_00FF);
    chk("reset_seg", 32'(seg_out), 32'h0000_FFFF);
    reset = 1'b0;
    tick();
    chk("first_sel", 32'(sel_out[3:0]), 32'h0000_000E);
    chk("first_seg", 32'(seg_out[7:0]), 32'h0000_00C0);

    // Scan sequence right after release: each select held SD cycles.
    for (int c = 2; c <= 17; c++) begin
      tick();
      chk("scan_sel", 32'(sel_out[3:0]), 32'(4'(~(4'b0001 << (((c - 1) / SD) % 4)))));
    end

    bus_write(32'h7f50, 4'hF, 32'h0123_456F);
    Addr = 32'h7f50; #1;
    chk("rd_data0", RD, 32'h0123_456F);
    chk("tube_num_data0", tube_num, 32'h0123_456F);
    for (int c = 0; c < 17; c++) begin
      tick();
      chk("grp1_digit", 32'(seg_out[15:8]), 32'(g1_exp[active_digit(sel_out[3:0])]));
      if (sel_out[3:0] == 4'b1110) chk("grp0_digit0_F", 32'(seg_out[7:0]), 32'h0000_008E);
    end

    for (int v = 0; v < 11; v++) begin
      bus_write(vecs[v].addr, vecs[v].be, vecs[v].wd);
      Addr = vecs[v].addr; #1;
      chk("vec_rd", RD, vecs[v].exp_rd);
    end

    // Leading-zero suppression with DATA0=0x50.
    bus_write(32'h7f58, 4'hF, 32'h0000_0003);
    bus_write(32'h7f50, 4'hF, 32'h0000_0050);
    for (int c = 0; c < 17; c++) begin
      tick();
      chk("lzs_grp0", 32'(seg_out[7:0]), 32'(lzs_g0[active_digit(sel_out[3:0])]));
      chk("lzs_grp1", 32'(seg_out[15:8]), 32'(lzs_g1[active_digit(sel_out[3:0])]));
    end

    bus_write(32'h7f58, 4'hF, 32'h0000_0000);
    tick();
    chk("dis_sel", 32'(sel_out), 32'h0000_00FF);
    chk("dis_aux_sel", 32'(aux_sel), 32'h0000_0001);
    chk("dis_seg", 32'(seg_out), 32'h0000_FFFF);
    bus_write(32'h7f58, 4'hF, 32'h0000_0001);
    for (int c = 0; c < 6; c++) tick();

    // Reset mid-scan at index 2, div_cnt 1.
    begin
      logic found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
        if ((m_ticks / SD) % 4 == 2 && m_ticks % SD == 1) found = 1'b1;
        else tick();
      end
      chk("reset_phase_found", 32'(found), 32'h1);
    end
    reset = 1'b1;
    tick();
    chk("mid_reset_sel", 32'(sel_out), 32'h0000_00FF);
    chk("mid_reset_seg", 32'(seg_out), 32'h0000_FFFF);
    chk("mid_reset_tube", tube_num, 32'h0);
    Addr = 32'h7f58; #1;
    chk("mid_reset_ctrl", RD, 32'h0000_0001);
    reset = 1'b0;
    tick();
    chk("post_reset_sel", 32'(sel_out[3:0]), 32'h0000_000E);

    // Randomized traffic against the model.
    for (int it = 0; it < 400; it++) begin
      logic [31:0] addrs [5] = '{32'h7f50, 32'h7f54, 32'h7f58, 32'h7f5C, 32'h7f4C};
      reset  = ($urandom % 64) == 0;
      we     = $urandom % 2;
      Addr   = addrs[$urandom % 5] | ($urandom % 4);
      byteen = 4'($urandom);
      WD     = $urandom;
      if (word_of(Addr) == NW + 1) begin
        WD[2] = 1'b0;
        WD[0] = ($urandom % 4) != 0;
      end
      tick();
      reset = 1'b0; we = 1'b0;
      Addr = addrs[$urandom % 5] | ($urandom % 4);
      #1;
      chk("rand_rd", RD, model_rd(Addr));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
